// File: rtl/alu_pkg.sv
// Shared ALU constants and types: datapath width and the carry-lookahead group size.
package alu_pkg;

  localparam int ALU_WIDTH = 16;
  localparam int CLA_GROUP = 4;

  typedef logic [ALU_WIDTH-1:0] word_t;

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead group: local sum plus group generate/propagate for the next lookahead level.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       g,
  output logic       p,
  output logic       cout
);

  logic [3:0] bit_g;
  logic [3:0] bit_p;
  logic [3:0] c;

  assign bit_g = a & b;
  assign bit_p = a ^ b;

  // Every internal carry is a flat sum-of-products of cin, so no carry ripples inside the group.
  assign c[0] = cin;
  assign c[1] = bit_g[0] | (bit_p[0] & cin);
  assign c[2] = bit_g[1] | (bit_p[1] & bit_g[0]) | (bit_p[1] & bit_p[0] & cin);
  assign c[3] = bit_g[2] | (bit_p[2] & bit_g[1]) | (bit_p[2] & bit_p[1] & bit_g[0])
              | (bit_p[2] & bit_p[1] & bit_p[0] & cin);

  assign g = bit_g[3] | (bit_p[3] & bit_g[2]) | (bit_p[3] & bit_p[2] & bit_g[1])
           | (bit_p[3] & bit_p[2] & bit_p[1] & bit_g[0]);
  assign p = &bit_p;

  assign sum  = bit_p ^ c;
  assign cout = g | (p & cin);

endmodule

// File: rtl/add16_reg.sv
// Registered WIDTH-bit adder: 4-bit CLA groups joined by a second-level lookahead unit.
// Handshake: a result is captured at every rising edge where in_valid is high (no backpressure);
// out_valid is high for exactly the cycle after each such edge, and sum/carry_out/overflow hold otherwise.
module add16_reg
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH  // positive multiple of CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NG = WIDTH / CLA_GROUP;

  logic [WIDTH-1:0] sum_c;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NG-1:0]    grp_cout;
  logic [NG:0]      grp_c;
  logic             la_acc;
  logic             la_pp;
  logic             carry_c;
  logic             overflow_c;
  logic             unused_cout;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla4 u_cla4 (
      .a    (a[gi*CLA_GROUP +: CLA_GROUP]),
      .b    (b[gi*CLA_GROUP +: CLA_GROUP]),
      .cin  (grp_c[gi]),
      .sum  (sum_c[gi*CLA_GROUP +: CLA_GROUP]),
      .g    (grp_g[gi]),
      .p    (grp_p[gi]),
      .cout (grp_cout[gi])
    );
  end

  // Each group carry is its own OR of products over lower groups' G/P and carry_in,
  // so no group waits on the carry of the group below it.
  always_comb begin
    grp_c    = '0;
    grp_c[0] = carry_in;
    la_acc   = 1'b0;
    la_pp    = 1'b1;
    for (int g = 0; g < NG; g++) begin
      la_acc = 1'b0;
      la_pp  = 1'b1;
      for (int j = g; j >= 0; j--) begin
        la_acc = la_acc | (grp_g[j] & la_pp);
        la_pp  = la_pp & grp_p[j];
      end
      grp_c[g+1] = la_acc | (la_pp & carry_in);
    end
  end

  // The group-local couts duplicate the lookahead carries; only the lookahead ones are used.
  assign unused_cout = ^grp_cout;

  assign carry_c    = grp_c[NG];
  assign overflow_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum       <= sum_c;
        carry_out <= carry_c;
        overflow  <= overflow_c;
      end
    end
  end

endmodule

// File: tb/tb_add16_reg.sv
// Bench for add16_reg: directed corner steps then randomized traffic against an arithmetic reference.
module tb_add16_reg;
  import alu_pkg::*;

  localparam int W = ALU_WIDTH;

  // clock / reset
  logic  clk = 1'b0;
  logic  rst_n = 1'b1;
  logic  in_valid = 1'b0;
  logic  carry_in = 1'b0;
  word_t a = '0;
  word_t b = '0;
  logic  out_valid;
  logic  carry_out;
  logic  overflow;
  word_t sum;

  always #5 clk = ~clk;

  add16_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  // scoreboard: expected {carry_out, overflow, sum} per accepted operand set
  logic [W+1:0] exp_q[$];
  logic         m_valid = 1'b0;
  word_t        m_sum = '0;
  logic         m_co = 1'b0;
  logic         m_ov = 1'b0;
  int           checks = 0;
  int           passes = 0;
  int           fails = 0;

  // Reference: plain integer arithmetic; overflow means the signed result leaves the W-bit range.
  function automatic logic [W+1:0] ref_add(word_t x, word_t y, logic c);
    longint us, ss, smax, smin;
    logic   ov;
    us   = longint'(x) + longint'(y) + longint'(c);
    ss   = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    ov   = (ss > smax) || (ss < smin);
    return {us[W], ov, us[W-1:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_valid = 1'b0;
    m_sum   = '0;
    m_co    = 1'b0;
    m_ov    = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".sum"},       32'(sum),       32'(m_sum));
    chk({tag, ".carry_out"}, 32'(carry_out), 32'(m_co));
    chk({tag, ".overflow"},  32'(overflow),  32'(m_ov));
  endtask

  // driver: apply operands, take one rising edge, then compare 1 time unit later
  task automatic step(input string tag, input logic v, input word_t x, input word_t y, input logic c);
    logic [W+1:0] e;
    in_valid = v;
    a        = x;
    b        = y;
    carry_in = c;
    @(posedge clk);
    if (!rst_n) model_clear();
    else if (v) begin
      exp_q.push_back(ref_add(x, y, c));
      m_valid = 1'b1;
    end else m_valid = 1'b0;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      {m_co, m_ov, m_sum} = e;
    end
    check_outputs(tag);
  endtask

  // asserts reset between edges; outputs must clear without a clock
  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_clear();
    check_outputs(tag);
  endtask

  initial begin
    logic  v;
    word_t x;
    word_t y;
    logic  c;

    // reset with a valid input pending: it must be discarded
    #1;
    in_valid = 1'b1;
    a        = 16'h1234;
    b        = 16'h1111;
    async_reset("reset_async");
    step("reset_hold", 1'b1, 16'h1234, 16'h1111, 1'b0);
    chk("reset_hold.sum_zero", 32'(sum), 32'h0);
    rst_n = 1'b1;

    step("cin_only", 1'b1, 16'h0000, 16'h0000, 1'b1);
    chk("cin_only.sum", 32'(sum), 32'h0001);
    chk("cin_only.co", 32'(carry_out), 32'h0);

    step("small_1_1_0", 1'b1, 16'h0001, 16'h0001, 1'b0);
    chk("small_1_1_0.sum", 32'(sum), 32'h0002);
    step("small_1_1_1", 1'b1, 16'h0001, 16'h0001, 1'b1);
    chk("small_1_1_1.sum", 32'(sum), 32'h0003);
    step("small_1_0_1", 1'b1, 16'h0001, 16'h0000, 1'b1);
    chk("small_1_0_1.sum", 32'(sum), 32'h0002);

    step("chain_c0", 1'b1, 16'hAAAA, 16'h5555, 1'b0);
    chk("chain_c0.sum", 32'(sum), 32'hFFFF);
    chk("chain_c0.co", 32'(carry_out), 32'h0);
    step("chain_c1", 1'b1, 16'hAAAA, 16'h5555, 1'b1);
    chk("chain_c1.sum", 32'(sum), 32'h0000);
    chk("chain_c1.co", 32'(carry_out), 32'h1);
    chk("chain_c1.ov", 32'(overflow), 32'h0);

    step("wrap_ffff_1", 1'b1, 16'hFFFF, 16'h0001, 1'b0);
    chk("wrap_ffff_1.sum", 32'(sum), 32'h0000);
    chk("wrap_ffff_1.co", 32'(carry_out), 32'h1);
    step("sat_c0", 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
    chk("sat_c0.sum", 32'(sum), 32'hFFFE);
    chk("sat_c0.co", 32'(carry_out), 32'h1);
    step("sat_c1", 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    chk("sat_c1.sum", 32'(sum), 32'hFFFF);
    chk("sat_c1.co", 32'(carry_out), 32'h1);
    step("sgn_ovf", 1'b1, 16'h7FFF, 16'h0001, 1'b0);
    chk("sgn_ovf.sum", 32'(sum), 32'h8000);
    chk("sgn_ovf.co", 32'(carry_out), 32'h0);
    chk("sgn_ovf.ov", 32'(overflow), 32'h1);
    step("neg_ovf", 1'b1, 16'h8000, 16'h8000, 1'b0);
    chk("neg_ovf.ov", 32'(overflow), 32'h1);

    // valid handling: three back-to-back results, then one idle cycle must hold the third
    step("vh_1", 1'b1, 16'h0010, 16'h0020, 1'b0);
    step("vh_2", 1'b1, 16'h0100, 16'h0200, 1'b0);
    step("vh_3", 1'b1, 16'h1000, 16'h2000, 1'b1);
    chk("vh_3.valid", 32'(out_valid), 32'h1);
    step("vh_idle", 1'b0, 16'hDEAD, 16'hBEEF, 1'b1);
    chk("vh_idle.valid", 32'(out_valid), 32'h0);
    chk("vh_idle.sum_held", 32'(sum), 32'h3001);
    step("vh_idle2", 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    chk("vh_idle2.sum_held", 32'(sum), 32'h3001);

    // randomized traffic with a reset pulse in the middle
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        async_reset("rand_reset_async");
        step("rand_reset_hold", 1'b1, word_t'($urandom), word_t'($urandom), 1'b1);
        rst_n = 1'b1;
      end
      v = ($urandom_range(0, 3) != 0);
      x = word_t'($urandom);
      y = word_t'($urandom);
      c = 1'($urandom_range(0, 1));
      if (!v) begin
        x = 'x;
        y = 'x;
        c = 'x;
      end
      step("rand", v, x, y, c);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
